threshold_monitor: RTL and testbench
====================================

THRESHOLD_MONITOR -- requirements
Module: threshold_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the operand width in bits.
REQ-002 SHALL have parameter ALARM_CNT, default 3, the number of consecutive GT samples needed to raise the alarm (legal range 1..15).
REQ-003 SHALL have parameter CLEAR_CNT, default 2, the number of consecutive non-GT samples needed to clear the alarm (legal range 1..15).
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 thr_load  input  1  load thr_in into the threshold register.
REQ-006 thr_in  input  WIDTH  new threshold value.
REQ-007 s_valid  input  1  sample valid.
REQ-008 s_ready  output  1  sample ready; combinational, equal to ~thr_load.
REQ-009 s_data  input  WIDTH  unsigned sample.
REQ-010 flag_valid  output  1  registered; GT/LT/EQ describe the last accepted sample.
REQ-011 gt_out, lt_out, eq_out  output  1 each  registered compare flags, one-hot when flag_valid=1.
REQ-012 alarm  output  1  registered alarm level.
REQ-013 alarm_rise  output  1  one-cycle pulse on alarm entry.
REQ-014 event_count  output  8  number of alarm entries.

Function
REQ-015 A sample SHALL be accepted on a rising clk edge only when s_valid=1 and s_ready=1.
REQ-016 The threshold register SHALL capture thr_in on any edge where thr_load=1; thr_load SHALL take priority over sample acceptance.
REQ-017 Each accepted sample SHALL be compared as unsigned s_data against the threshold value held before that edge; the flags SHALL appear one cycle later (latency 1) with flag_valid=1.
REQ-018 On a cycle with no accepted sample, flag_valid SHALL be 0 and gt/lt/eq SHALL hold their previous values.
REQ-019 The FSM SHALL have states NORMAL, PENDING, ALARM and CLEARING, plus a 4-bit saturating run counter; it SHALL update only on accepted samples or on thr_load.
REQ-020 NORMAL: on GT, run=1 and next state is PENDING; if ALARM_CNT=1, next state is ALARM instead. On non-GT, stay in NORMAL.
REQ-021 PENDING: on GT, run+1; when run+1 equals ALARM_CNT, go to ALARM. On LT or EQ, go to NORMAL with run=0.
REQ-022 ALARM: on GT, stay in ALARM. On non-GT, run=1 and go to CLEARING; if CLEAR_CNT=1, go to NORMAL instead.
REQ-023 CLEARING: on non-GT, run+1; when run+1 equals CLEAR_CNT, go to NORMAL. On GT, go to ALARM with run=0.
REQ-024 alarm SHALL be 1 exactly while the registered state is ALARM or CLEARING.
REQ-025 alarm_rise SHALL pulse for one cycle in the cycle alarm goes 0 to 1; event_count SHALL increment in that same cycle and saturate at 255.
REQ-026 thr_load=1 SHALL force state NORMAL and run=0 on that edge (alarm drops the next cycle) and SHALL leave event_count and the flags unchanged.
REQ-027 EQ SHALL count as non-GT for both raising and clearing.

Reset
REQ-028 On rst_n=0, the block SHALL asynchronously set the threshold to 0, the state to NORMAL and run to 0, and drive flag_valid=0, gt_out=0, lt_out=0, eq_out=0, alarm=0, alarm_rise=0 and event_count=0.
REQ-029 Reset asserted mid-operation SHALL abandon any in-progress run; the first accepted sample after release SHALL be compared against threshold 0.

Structure
REQ-030 The state enum, the WIDTH default and the 8-bit event-count width SHALL live in shared package threshold_pkg.
REQ-031 The magnitude compare SHALL be a single instantiated sub-module, Comparator (A, B -> GT, LT, EQ), wired with A=s_data and B=threshold.
REQ-032 The FSM, run counter, flag registers and event counter SHALL be in threshold_monitor.

Verification
REQ-033 Reset, then load threshold 5, then samples 6,7,8 -> alarm=1 and alarm_rise pulses one cycle after the third accept; event_count=1.
REQ-034 Threshold 5, samples 6,7,5,6,7,8 -> EQ resets the run; alarm rises only after the 8; event_count=1.
REQ-035 While in alarm, samples 2,9,2,2 -> CLEARING, back to ALARM, CLEARING, then NORMAL; alarm=0 after the last 2; no extra alarm_rise.
REQ-036 thr_load=1 with s_valid=1 -> s_ready=0, sample not accepted, flag_valid=0 next cycle, and a PENDING run is cleared.
REQ-037 rst_n pulsed low mid-PENDING -> all outputs go to 0 immediately; sample 1 after release gives gt_out=1 (threshold 0).
REQ-038 256 alarm entries -> event_count saturates at 255; alarm_rise still pulses on each entry.

Source files
------------

// File: rtl/threshold_pkg.sv
// Shared types and widths for the threshold monitor: alarm FSM states,
// default operand width and the alarm-entry counter width.
package threshold_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int EVT_W     = 8;
    localparam int RUN_W     = 4;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_PENDING  = 2'd1,
        ST_ALARM    = 2'd2,
        ST_CLEARING = 2'd3
    } state_t;

endpackage

// File: rtl/Comparator.sv
// Unsigned magnitude compare of A against B; exactly one output is high.
module Comparator
    import threshold_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             GT,
    output logic             LT,
    output logic             EQ
);

    assign GT = (A > B);
    assign LT = (A < B);
    assign EQ = (A == B);

endmodule

// File: rtl/threshold_monitor.sv
// Compares accepted samples against a loadable threshold and raises a debounced
// alarm after ALARM_CNT consecutive GT samples, clearing after CLEAR_CNT non-GT.
module threshold_monitor
    import threshold_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ALARM_CNT = 3,
    parameter int CLEAR_CNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             thr_load,
    input  logic [WIDTH-1:0] thr_in,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             flag_valid,
    output logic             gt_out,
    output logic             lt_out,
    output logic             eq_out,
    output logic             alarm,
    output logic             alarm_rise,
    output logic [EVT_W-1:0] event_count
);

    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (v == {RUN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [EVT_W-1:0] sat_inc_evt(input logic [EVT_W-1:0] v);
        return (v == {EVT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    localparam logic [RUN_W-1:0] ALARM_RUN = RUN_W'(ALARM_CNT);
    localparam logic [RUN_W-1:0] CLEAR_RUN = RUN_W'(CLEAR_CNT);

    logic [WIDTH-1:0] thr_p0;
    state_t           state_p0, state_n;
    logic [RUN_W-1:0] run_p0, run_n, run_inc;
    logic             cmp_gt, cmp_lt, cmp_eq;
    logic             accept;
    logic             alarm_n;

    assign s_ready = ~thr_load;
    assign accept  = s_valid & s_ready;
    assign run_inc = sat_inc_run(run_p0);

    // The compare sees the threshold held before this edge.
    Comparator #(.WIDTH(WIDTH)) u_cmp (
        .A  (s_data),
        .B  (thr_p0),
        .GT (cmp_gt),
        .LT (cmp_lt),
        .EQ (cmp_eq)
    );

    always_comb begin
        state_n = state_p0;
        run_n   = run_p0;
        if (thr_load) begin
            state_n = ST_NORMAL;
            run_n   = '0;
        end else if (accept) begin
            unique case (state_p0)
                ST_NORMAL: begin
                    if (cmp_gt) begin
                        run_n   = RUN_W'(1);
                        state_n = (ALARM_CNT == 1) ? ST_ALARM : ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (cmp_gt) begin
                        run_n = run_inc;
                        if (run_inc == ALARM_RUN) state_n = ST_ALARM;
                    end else begin
                        run_n   = '0;
                        state_n = ST_NORMAL;
                    end
                end
                ST_ALARM: begin
                    if (!cmp_gt) begin
                        if (CLEAR_CNT == 1) begin
                            run_n   = '0;
                            state_n = ST_NORMAL;
                        end else begin
                            run_n   = RUN_W'(1);
                            state_n = ST_CLEARING;
                        end
                    end
                end
                ST_CLEARING: begin
                    if (cmp_gt) begin
                        run_n   = '0;
                        state_n = ST_ALARM;
                    end else if (run_inc == CLEAR_RUN) begin
                        run_n   = '0;
                        state_n = ST_NORMAL;
                    end else begin
                        run_n = run_inc;
                    end
                end
                default: begin
                    run_n   = '0;
                    state_n = ST_NORMAL;
                end
            endcase
        end
        alarm_n = (state_n == ST_ALARM) || (state_n == ST_CLEARING);
    end

    // Stage p0 -> outputs: threshold, FSM, flags and alarm bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_p0      <= '0;
            state_p0    <= ST_NORMAL;
            run_p0      <= '0;
            flag_valid  <= 1'b0;
            gt_out      <= 1'b0;
            lt_out      <= 1'b0;
            eq_out      <= 1'b0;
            alarm       <= 1'b0;
            alarm_rise  <= 1'b0;
            event_count <= '0;
        end else begin
            if (thr_load) thr_p0 <= thr_in;
            state_p0   <= state_n;
            run_p0     <= run_n;
            flag_valid <= accept;
            if (accept) begin
                gt_out <= cmp_gt;
                lt_out <= cmp_lt;
                eq_out <= cmp_eq;
            end
            alarm      <= alarm_n;
            alarm_rise <= alarm_n & ~alarm;
            if (alarm_n && !alarm) event_count <= sat_inc_evt(event_count);
        end
    end

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed and randomized checks of threshold_monitor against a streak-count
// reference model of the alarm behaviour.
module tb_threshold_monitor;

    localparam int W  = 4;
    localparam int AC = 3;
    localparam int CC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         thr_load;
    logic [W-1:0] thr_in;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         flag_valid, gt_out, lt_out, eq_out;
    logic         alarm, alarm_rise;
    logic [7:0]   event_count;

    threshold_monitor #(.WIDTH(W), .ALARM_CNT(AC), .CLEAR_CNT(CC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .thr_load    (thr_load),
        .thr_in      (thr_in),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .flag_valid  (flag_valid),
        .gt_out      (gt_out),
        .lt_out      (lt_out),
        .eq_out      (eq_out),
        .alarm       (alarm),
        .alarm_rise  (alarm_rise),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rise_seen = 0;

    // Reference model: consecutive GT / non-GT streak lengths since the last
    // opposite sample, threshold load or reset.
    int         m_thr, m_gs, m_ns, m_cnt;
    logic       m_alarm, m_rise, m_fv, m_gt, m_lt, m_eq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_thr = 0; m_gs = 0; m_ns = 0; m_cnt = 0;
        m_alarm = 0; m_rise = 0; m_fv = 0; m_gt = 0; m_lt = 0; m_eq = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".flag_valid"}, 32'(flag_valid), 32'(m_fv));
        chk({tag, ".gt"}, 32'(gt_out), 32'(m_gt));
        chk({tag, ".lt"}, 32'(lt_out), 32'(m_lt));
        chk({tag, ".eq"}, 32'(eq_out), 32'(m_eq));
        chk({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
        chk({tag, ".alarm_rise"}, 32'(alarm_rise), 32'(m_rise));
        chk({tag, ".event_count"}, 32'(event_count), 32'(m_cnt));
    endtask

    task automatic step(input string tag, input logic ld, input logic [W-1:0] ti,
                        input logic v, input logic [W-1:0] d);
        logic was;
        thr_load = ld; thr_in = ti; s_valid = v; s_data = d;
        #1;
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(!ld));
        @(posedge clk);
        was = m_alarm;
        if (ld) begin
            m_thr = int'(ti); m_gs = 0; m_ns = 0; m_alarm = 0; m_fv = 0;
        end else if (v) begin
            m_fv = 1;
            m_gt = (int'(d) > m_thr);
            m_lt = (int'(d) < m_thr);
            m_eq = (int'(d) == m_thr);
            if (m_gt) begin m_gs++; m_ns = 0; end
            else begin m_ns++; m_gs = 0; end
            if (!m_alarm && m_gs >= AC) m_alarm = 1;
            else if (m_alarm && m_ns >= CC) begin m_alarm = 0; m_gs = 0; end
        end else begin
            m_fv = 0;
        end
        m_rise = m_alarm & ~was;
        if (m_rise && m_cnt < 255) m_cnt++;
        #1;
        if (alarm_rise) rise_seen++;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; thr_load = 0; thr_in = 0; s_valid = 0; s_data = 0;
        model_reset();
        #2;
        do_reset();

        // Rise after three GT samples
        step("r33_load", 1, 4'd5, 0, 0);
        step("r33_s6", 0, 0, 1, 4'd6);
        step("r33_s7", 0, 0, 1, 4'd7);
        step("r33_s8", 0, 0, 1, 4'd8);
        chk("r33_alarm", 32'(alarm), 32'd1);
        chk("r33_rise", 32'(alarm_rise), 32'd1);
        chk("r33_cnt", 32'(event_count), 32'd1);
        step("r33_idle", 0, 0, 0, 0);
        chk("r33_rise_off", 32'(alarm_rise), 32'd0);

        // EQ breaks the run
        do_reset();
        step("r34_load", 1, 4'd5, 0, 0);
        step("r34_s6", 0, 0, 1, 4'd6);
        step("r34_s7", 0, 0, 1, 4'd7);
        step("r34_s5", 0, 0, 1, 4'd5);
        chk("r34_eq", 32'(eq_out), 32'd1);
        step("r34_s6b", 0, 0, 1, 4'd6);
        step("r34_s7b", 0, 0, 1, 4'd7);
        chk("r34_noalarm", 32'(alarm), 32'd0);
        step("r34_s8", 0, 0, 1, 4'd8);
        chk("r34_alarm", 32'(alarm), 32'd1);
        chk("r34_cnt", 32'(event_count), 32'd1);

        // Clearing, re-entry to alarm, then clear
        step("r35_s2", 0, 0, 1, 4'd2);
        step("r35_s9", 0, 0, 1, 4'd9);
        step("r35_s2b", 0, 0, 1, 4'd2);
        chk("r35_still", 32'(alarm), 32'd1);
        step("r35_s2c", 0, 0, 1, 4'd2);
        chk("r35_clear", 32'(alarm), 32'd0);
        chk("r35_cnt", 32'(event_count), 32'd1);

        // Load beats a valid sample and clears a pending run
        step("r36_s6", 0, 0, 1, 4'd6);
        step("r36_s6b", 0, 0, 1, 4'd6);
        step("r36_ld", 1, 4'd5, 1, 4'd9);
        chk("r36_fv", 32'(flag_valid), 32'd0);
        step("r36_s6c", 0, 0, 1, 4'd6);
        step("r36_s6d", 0, 0, 1, 4'd6);
        chk("r36_noalarm", 32'(alarm), 32'd0);
        step("r36_s6e", 0, 0, 1, 4'd6);
        chk("r36_alarm", 32'(alarm), 32'd1);

        // Async reset mid-PENDING
        step("r37_ld", 1, 4'd5, 0, 0);
        step("r37_s6", 0, 0, 1, 4'd6);
        step("r37_s6b", 0, 0, 1, 4'd6);
        do_reset();
        chk("r37_cnt0", 32'(event_count), 32'd0);
        step("r37_s1", 0, 0, 1, 4'd1);
        chk("r37_gt", 32'(gt_out), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic         ld, v;
            logic [W-1:0] ti, d;
            ld = ($urandom_range(0, 15) == 0);
            v  = ($urandom_range(0, 3) != 0);
            ti = W'($urandom_range(0, 12));
            d  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(8, 15)) : W'($urandom);
            step("rand", ld, ti, v, d);
        end

        // Event counter saturation
        do_reset();
        rise_seen = 0;
        for (int n = 0; n < 256; n++) begin
            step("r38_a", 0, 0, 1, 4'd1);
            step("r38_b", 0, 0, 1, 4'd2);
            step("r38_c", 0, 0, 1, 4'd3);
            step("r38_ld", 1, 4'd0, 0, 0);
        end
        chk("r38_sat", 32'(event_count), 32'd255);
        chk("r38_rises", 32'(rise_seen), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
